// File: rtl/mem_dump_reader.sv
// mem_dump_reader: sweeps a contiguous, wrapping address window of a
// single-clock block RAM and streams the words out over valid/ready.
//   clk, reset (async, active-low)
//   start, base_addr, length : command, sampled only in IDLE
//   busy, done, err          : status; done/err are one-cycle pulses
//   mem_raddr, mem_dout      : memory read port (address registered here)
//   m_valid, m_data, m_last, m_ready : output stream
// The memory read data for an address registered at one edge is captured at
// the next edge. A 2-entry head/tail buffer decouples reads from backpressure.
module mem_dump_reader #(
  parameter int unsigned WID_MEM   = 4,
  parameter int unsigned DEPTH_MEM = 4096,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W-1:0]  length,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ADDR_W-1:0]  mem_raddr,
  input  logic [WID_MEM-1:0] mem_dout,
  output logic               m_valid,
  output logic [WID_MEM-1:0] m_data,
  output logic               m_last,
  input  logic               m_ready
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH_MEM);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH_MEM - 1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_remaining;
  logic [ADDR_W-1:0]   r_raddr;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_inflight;
  logic                r_inflight_last;

  logic                r_head_vld;
  logic [WID_MEM-1:0]  r_head_data;
  logic                r_head_last;
  logic                r_tail_vld;
  logic [WID_MEM-1:0]  r_tail_data;
  logic                r_tail_last;

  logic                w_pop;
  logic                w_push;
  logic [1:0]          w_occ;
  logic [1:0]          w_load;
  logic                w_issue;

  // A word popping this cycle frees its slot, which keeps one read per cycle
  // flowing under m_ready=1 while still never overfilling the buffer.
  assign w_pop   = r_head_vld & m_ready;
  assign w_push  = r_inflight;
  assign w_occ   = 2'(r_head_vld) + 2'(r_tail_vld);
  assign w_load  = w_occ + 2'(r_inflight) - 2'(w_pop);
  assign w_issue = (r_state == S_RUN) && (w_load < 2'd2);

  // Command acceptance, read issue and completion sequencing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_remaining     <= '0;
      r_raddr         <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_done          <= 1'b0;
      r_err           <= 1'b0;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_remaining == ONE_A);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if ((base_addr >= DEPTH_A) || (length > DEPTH_A)) begin
              r_err <= 1'b1;
            end else if (length == '0) begin
              r_done <= 1'b1;
            end else begin
              r_addr      <= base_addr;
              r_remaining <= length;
              r_busy      <= 1'b1;
              r_state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_issue) begin
            r_raddr     <= r_addr;
            r_addr      <= (r_addr == LAST_A) ? '0 : r_addr + ONE_A;
            r_remaining <= r_remaining - ONE_A;
            if (r_remaining == ONE_A) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_pop && r_head_last) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry output buffer: head drives the stream, tail absorbs one
  // extra captured word while the sink stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head_vld  <= 1'b0;
      r_head_data <= '0;
      r_head_last <= 1'b0;
      r_tail_vld  <= 1'b0;
      r_tail_data <= '0;
      r_tail_last <= 1'b0;
    end else if (w_push && w_pop) begin
      if (r_tail_vld) begin
        r_head_data <= r_tail_data;
        r_head_last <= r_tail_last;
        r_tail_data <= mem_dout;
        r_tail_last <= r_inflight_last;
      end else begin
        r_head_data <= mem_dout;
        r_head_last <= r_inflight_last;
      end
    end else if (w_push) begin
      if (!r_head_vld) begin
        r_head_vld  <= 1'b1;
        r_head_data <= mem_dout;
        r_head_last <= r_inflight_last;
      end else begin
        r_tail_vld  <= 1'b1;
        r_tail_data <= mem_dout;
        r_tail_last <= r_inflight_last;
      end
    end else if (w_pop) begin
      if (r_tail_vld) begin
        r_head_data <= r_tail_data;
        r_head_last <= r_tail_last;
        r_tail_vld  <= 1'b0;
        r_tail_last <= 1'b0;
      end else begin
        r_head_vld  <= 1'b0;
        r_head_last <= 1'b0;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign mem_raddr = r_raddr;
  assign m_valid   = r_head_vld;
  assign m_data    = r_head_data;
  assign m_last    = r_head_last;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: a behavioural memory plus a transfer-level model
// (expected words = mem[(base+i) mod depth]) checked beat by beat.
module tb_mem_dump_reader;

  localparam int WID   = 4;
  localparam int DEPTH = 4096;
  localparam int AW    = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [AW-1:0]   length = '0;
  logic            busy, done, err;
  logic [AW-1:0]   mem_raddr;
  logic [WID-1:0]  mem_dout;
  logic            m_valid;
  logic [WID-1:0]  m_data;
  logic            m_last;
  logic            m_ready = 1'b0;

  always #5 clk = ~clk;

  mem_dump_reader #(.WID_MEM(WID), .DEPTH_MEM(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .err(err),
    .mem_raddr(mem_raddr), .mem_dout(mem_dout), .m_valid(m_valid),
    .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
  );

  // Memory: the registered mem_raddr acts as the RAM's address latch.
  logic [WID-1:0] mem [DEPTH];
  logic [11:0]    rd_idx;
  assign rd_idx   = 12'(mem_raddr);
  assign mem_dout = mem[rd_idx];

  int n_checks = 0;
  int n_fail   = 0;
  bit pat [6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, 32'({busy, done, err, m_valid, m_last}), 32'd0);
    check({tag, "_data"}, 32'(m_data), 32'd0);
    check({tag, "_raddr"}, mem_raddr, 32'd0);
  endtask

  // rmode: 0 ready held high, 1 fixed toggle pattern, 2 random.
  // restart_cyc >= 0 pulses a second start mid-transfer; abort_beats > 0
  // asserts reset right after that many handshakes and returns.
  task automatic run_xfer(input int base, input int len, input int rmode,
                          input int restart_cyc, input int abort_beats);
    int exp_d[$];
    int exp_a[$];
    int seen_a[$];
    int cyc = 0;
    int got = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_hs = -1;
    int first_v = -1;
    int valid_seen = 0;
    int max_cyc = 30 * len + 60;
    bit held = 1'b0;
    logic [WID-1:0] held_d = '0;
    logic held_l = 1'b0;
    logic [AW-1:0] prev;
    logic [AW-1:0] cur_a;
    bit legal;
    legal = (base >= 0) && (base < DEPTH) && (len >= 0) && (len <= DEPTH);
    if (legal) begin
      for (int i = 0; i < len; i++) begin
        exp_a.push_back((base + i) % DEPTH);
        exp_d.push_back(int'(mem[(base + i) % DEPTH]));
      end
    end
    @(negedge clk);
    prev = mem_raddr;
    cur_a = prev;
    start = 1'b1; base_addr = AW'(base); length = AW'(len);
    @(negedge clk);
    start = 1'b0;

    if (!legal || len == 0) begin
      check("rej_err", 32'(err), legal ? 32'd0 : 32'd1);
      check("rej_done", 32'(done), legal ? 32'd1 : 32'd0);
      check("rej_busy", 32'(busy), 32'd0);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (m_valid || busy || done || err) valid_seen++;
      end
      check("rej_quiet", 32'(valid_seen), 32'd0);
      check("rej_raddr", mem_raddr, prev);
      return;
    end

    check("start_busy", 32'(busy), 32'd1);
    while (cyc < max_cyc) begin
      if (mem_raddr != cur_a) begin
        seen_a.push_back(int'(mem_raddr));
        cur_a = mem_raddr;
      end
      if (held) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(held_d));
        check("hold_last", 32'(m_last), 32'(held_l));
      end
      if (m_valid && first_v < 0) first_v = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_busy", 32'(busy), 32'd0);
        break;
      end
      if (cyc == restart_cyc) begin
        start = 1'b1; base_addr = AW'(100); length = AW'(3);
      end else begin
        start = 1'b0; base_addr = AW'(base); length = AW'(len);
      end
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = pat[cyc % 6];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (m_valid && m_ready) begin
        if (got < len) begin
          check("beat_data", 32'(m_data), 32'(exp_d[got]));
          check("beat_last", 32'(m_last), (got == len - 1) ? 32'd1 : 32'd0);
        end else begin
          check("extra_beat", 32'(got + 1), 32'(len));
        end
        got++;
        last_hs = cyc;
        held = 1'b0;
      end else begin
        held = m_valid;
        held_d = m_data;
        held_l = m_last;
      end
      @(negedge clk);
      cyc++;
      if (abort_beats > 0 && got == abort_beats) begin
        start = 1'b0;
        m_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        return;
      end
    end
    start = 1'b0;
    check("timeout", (done_cyc >= 0) ? 32'd1 : 32'd0, 32'd1);
    check("beat_count", 32'(got), 32'(len));
    check("done_timing", 32'(done_cyc), 32'(last_hs + 1));
    if (rmode == 0) begin
      check("first_valid", 32'(first_v), 32'd2);
      check("burst_end", 32'(last_hs), 32'(2 + len - 1));
    end
    if (exp_a.size() > 0 && exp_a[0] == int'(prev)) void'(exp_a.pop_front());
    check("addr_count", 32'(seen_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < seen_a.size(); i++)
      check("addr_seq", 32'(seen_a[i]), 32'(exp_a[i]));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy || m_valid) valid_seen++;
    end
    check("done_once", 32'(done_cnt), 32'd1);
    check("idle_after", 32'(valid_seen), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = WID'(i);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    run_xfer(0, 8, 0, -1, 0);
    run_xfer(4094, 4, 0, -1, 0);
    run_xfer(20, 6, 1, -1, 0);
    run_xfer(5, 0, 0, -1, 0);
    run_xfer(4096, 1, 0, -1, 0);
    run_xfer(0, 4097, 0, -1, 0);
    run_xfer(4095, 4096, 0, -1, 0);

    run_xfer(0, 10, 0, -1, 3);
    repeat (2) @(negedge clk);
    check_all_zero("reset_hold");
    rst_n = 1'b1;
    run_xfer(0, 2, 0, -1, 0);

    run_xfer(30, 5, 0, 3, 0);

    for (int i = 0; i < DEPTH; i++) mem[i] = WID'($urandom);
    for (int t = 0; t < 24; t++) begin
      int b;
      int l;
      b = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4096, 5000))
                                      : int'($urandom_range(0, DEPTH - 1));
      l = ($urandom_range(0, 9) == 0) ? 4097 : int'($urandom_range(0, 40));
      run_xfer(b, l, ($urandom_range(0, 3) == 0) ? 0 : 2, -1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
